// File: rtl/mem_arbiter.sv
// mem_arbiter: merges itim and dtim request streams onto one external memory port.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is data-first with an instr starvation guard.
package mem_arbiter_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int starve_limit = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);
    localparam int SRC_I = 0;
    localparam int SRC_D = 1;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t     state_reg, state_next;
    mem_in_type slot_i_reg, slot_i_next;
    mem_in_type slot_d_reg, slot_d_next;

    logic [1:0] src_valid;
    logic [1:0] slot_valid;
    logic [1:0] done;
    logic [1:0] take;
    logic       decide;
    logic       elig_i;
    logic       elig_d;
    logic       grant_i;

`ifdef MEM_ARBITER_RR_EN
    logic rr_instr_reg, rr_instr_next;   // 1: instr wins the next collision
`else
    localparam int CNT_W = $clog2(starve_limit + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(starve_limit);
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
`endif

    assign src_valid  = {dmem_in.mem_valid, imem_in.mem_valid};
    assign slot_valid = {slot_d_reg.mem_valid, slot_i_reg.mem_valid};
    assign done[SRC_I] = rst && (state_reg == BUSY_I) && mem_out.mem_ready;
    assign done[SRC_D] = rst && (state_reg == BUSY_D) && mem_out.mem_ready;

    // A source may only post a new request once its previous one has completed,
    // which includes the very edge on which it completes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_take
            assign take[gi] = src_valid[gi] && (!slot_valid[gi] || done[gi]);
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        slot_i_next = slot_i_reg;
        slot_d_next = slot_d_reg;
        decide      = 1'b0;
        elig_i      = 1'b0;
        elig_d      = 1'b0;
        grant_i     = 1'b0;
        mem_in      = '0;
        imem_out    = '0;
        dmem_out    = '0;

        if (take[SRC_I]) begin
            slot_i_next = imem_in;
        end else if (done[SRC_I]) begin
            slot_i_next.mem_valid = 1'b0;
        end
        if (take[SRC_D]) begin
            slot_d_next = dmem_in;
        end else if (done[SRC_D]) begin
            slot_d_next.mem_valid = 1'b0;
        end

        // The completing source competes with its reloaded request so that a
        // continuously requesting source keeps the port back-to-back.
        case (state_reg)
            IDLE: begin
                decide = 1'b1;
                elig_i = slot_i_reg.mem_valid;
                elig_d = slot_d_reg.mem_valid;
            end
            BUSY_I: begin
                mem_in           = slot_i_reg;
                mem_in.mem_instr = 1'b1;
                if (mem_out.mem_ready) begin
                    imem_out = mem_out;
                    decide   = 1'b1;
                    elig_i   = take[SRC_I];
                    elig_d   = slot_d_reg.mem_valid;
                end
            end
            BUSY_D: begin
                mem_in           = slot_d_reg;
                mem_in.mem_instr = 1'b0;
                if (mem_out.mem_ready) begin
                    dmem_out = mem_out;
                    decide   = 1'b1;
                    elig_i   = slot_i_reg.mem_valid;
                    elig_d   = take[SRC_D];
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef MEM_ARBITER_RR_EN
        rr_instr_next = rr_instr_reg;
        grant_i       = elig_i && (!elig_d || rr_instr_reg);
`else
        starve_cnt_next = starve_cnt_reg;
        grant_i         = elig_i && (!elig_d || (starve_cnt_reg == STARVE_MAX));
`endif

        if (decide) begin
            if (elig_i || elig_d) begin
                state_next = grant_i ? BUSY_I : BUSY_D;
`ifdef MEM_ARBITER_RR_EN
                rr_instr_next = !grant_i;
`else
                if (grant_i) begin
                    starve_cnt_next = '0;
                end else if (elig_i && (starve_cnt_reg != STARVE_MAX)) begin
                    starve_cnt_next = starve_cnt_reg + CNT_W'(1);
                end
`endif
            end else begin
                state_next = IDLE;
            end
        end

        if (!rst) begin
            mem_in   = '0;
            imem_out = '0;
            dmem_out = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            slot_i_reg     <= '0;
            slot_d_reg     <= '0;
`ifdef MEM_ARBITER_RR_EN
            rr_instr_reg   <= 1'b0;
`else
            starve_cnt_reg <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            slot_i_reg     <= slot_i_next;
            slot_d_reg     <= slot_d_next;
`ifdef MEM_ARBITER_RR_EN
            rr_instr_reg   <= rr_instr_next;
`else
            starve_cnt_reg <= starve_cnt_next;
`endif
        end
    end
endmodule
